// File: rtl/spi_master.sv
// SPI mode-0 initiator, MSB first, 32-bit frames, with chip-select setup/hold/idle timing.
// Optional irq_o/irq_clr_i ports are present when SPI_MASTER_IRQ_EN is defined.
//
// state | meaning
// IDLE  | ss high, waiting for start_i
// SETUP | ss low, sclk low, chip-select setup time
// XFER  | 32 bits, low half then high half per bit
// HOLD  | ss still low after the last falling edge
// GAP   | ss high, busy still high, minimum deselect time
module spi_master #(
  parameter int CLK_DIV  = 4,
  parameter int CS_SETUP = 4,
  parameter int CS_HOLD  = 2,
  parameter int CS_IDLE  = 4
) (
  input  logic        sclk_i,
  input  logic        rst_ni,
  input  logic        start_i,
  input  logic [31:0] tx_data_i,
  output logic [31:0] rx_data_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        spi_sclk_o,
  output logic        spi_ss_no,
  output logic        spi_mosi_o,
  input  logic        spi_miso_i
`ifdef SPI_MASTER_IRQ_EN
  ,
  output logic        irq_o,
  input  logic        irq_clr_i
`endif
);

  localparam int HW = $clog2(CLK_DIV + 1);
  localparam int M1 = (CS_SETUP > CS_HOLD) ? CS_SETUP - 1 : CS_HOLD - 1;
  localparam int WAIT_MAX = (M1 > CS_IDLE) ? M1 : CS_IDLE;
  localparam int WW = $clog2(WAIT_MAX + 1);

  localparam logic [HW-1:0] HALF_LAST  = HW'(CLK_DIV - 1);
  localparam logic [WW-1:0] SETUP_LAST = WW'(CS_SETUP - 1);
  localparam logic [WW-1:0] HOLD_LAST  = WW'(CS_HOLD - 1);
  // GAP runs one cycle longer than CS_IDLE so busy covers the accept cycle too.
  localparam logic [WW-1:0] GAP_LAST   = WW'(CS_IDLE);

  typedef enum logic [2:0] {IDLE, SETUP, XFER, HOLD, GAP} state_t;

  state_t        state_q, state_d;
  logic [HW-1:0] half_q, half_d;
  logic [5:0]    bit_q, bit_d;
  logic [WW-1:0] wait_q, wait_d;
  logic [31:0]   tx_q, tx_d;
  logic [31:0]   rx_sh_q, rx_sh_d;
  logic [31:0]   rx_data_d;
  logic          busy_d, done_d, sclk_d, ss_d, mosi_d;

  always_ff @(posedge sclk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      half_q     <= '0;
      bit_q      <= '0;
      wait_q     <= '0;
      tx_q       <= '0;
      rx_sh_q    <= '0;
      rx_data_o  <= '0;
      busy_o     <= 1'b0;
      done_o     <= 1'b0;
      spi_sclk_o <= 1'b0;
      spi_ss_no  <= 1'b1;
      spi_mosi_o <= 1'b0;
    end else begin
      state_q    <= state_d;
      half_q     <= half_d;
      bit_q      <= bit_d;
      wait_q     <= wait_d;
      tx_q       <= tx_d;
      rx_sh_q    <= rx_sh_d;
      rx_data_o  <= rx_data_d;
      busy_o     <= busy_d;
      done_o     <= done_d;
      spi_sclk_o <= sclk_d;
      spi_ss_no  <= ss_d;
      spi_mosi_o <= mosi_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    half_d    = half_q;
    bit_d     = bit_q;
    wait_d    = wait_q;
    tx_d      = tx_q;
    rx_sh_d   = rx_sh_q;
    rx_data_d = rx_data_o;
    busy_d    = busy_o;
    done_d    = 1'b0;
    sclk_d    = spi_sclk_o;
    ss_d      = spi_ss_no;
    mosi_d    = spi_mosi_o;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d = SETUP;
          tx_d    = tx_data_i;
          busy_d  = 1'b1;
          ss_d    = 1'b0;
          mosi_d  = tx_data_i[31];
          half_d  = '0;
          bit_d   = '0;
          wait_d  = '0;
        end
      end
      SETUP: begin
        if (wait_q == SETUP_LAST) begin
          state_d = XFER;
          half_d  = '0;
          bit_d   = '0;
          wait_d  = '0;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      XFER: begin
        if (half_q != HALF_LAST) begin
          half_d = half_q + 1'b1;
        end else begin
          half_d = '0;
          if (!spi_sclk_o) begin
            sclk_d  = 1'b1;
            rx_sh_d = {rx_sh_q[30:0], spi_miso_i};
          end else begin
            sclk_d = 1'b0;
            if (bit_q == 6'd31) begin
              mosi_d  = 1'b0;
              state_d = HOLD;
              bit_d   = '0;
              wait_d  = '0;
            end else begin
              tx_d   = {tx_q[30:0], 1'b0};
              mosi_d = tx_q[30];
              bit_d  = bit_q + 6'd1;
            end
          end
        end
      end
      HOLD: begin
        if (wait_q == HOLD_LAST) begin
          state_d   = GAP;
          ss_d      = 1'b1;
          rx_data_d = rx_sh_q;
          done_d    = 1'b1;
          half_d    = '0;
          bit_d     = '0;
          wait_d    = '0;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      GAP: begin
        if (wait_q == GAP_LAST) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          half_d  = '0;
          bit_d   = '0;
          wait_d  = '0;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef SPI_MASTER_IRQ_EN
  // Set has priority so a clear coinciding with done cannot lose the event.
  always_ff @(posedge sclk_i or negedge rst_ni) begin
    if (!rst_ni)        irq_o <= 1'b0;
    else if (done_o)    irq_o <= 1'b1;
    else if (irq_clr_i) irq_o <= 1'b0;
  end
`endif

endmodule

// File: tb/tb_spi_master.sv
// Directed bench for spi_master: loopback, behavioural slave, timing, dropped starts, abort.
// Build with SPI_MASTER_IRQ_EN defined to also exercise the interrupt ports.
module tb_spi_master;
  localparam int CLK_DIV  = 2;
  localparam int CS_SETUP = 4;
  localparam int CS_HOLD  = 2;
  localparam int CS_IDLE  = 4;
  localparam int BUSY_LEN = 1 + CS_SETUP + 64 * CLK_DIV + CS_HOLD + CS_IDLE;
  localparam int SS_LEN   = CS_SETUP + 64 * CLK_DIV + CS_HOLD;

  logic        sclk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        start_i = 1'b0;
  logic [31:0] tx_data_i = '0;
  logic [31:0] rx_data_o;
  logic        busy_o, done_o, spi_sclk_o, spi_ss_no, spi_mosi_o, spi_miso_i;
  logic        irq_clr_i = 1'b0;
`ifdef SPI_MASTER_IRQ_EN
  logic        irq_o;
`endif

  int checks = 0;
  int errors = 0;

  // slave model and monitors
  logic        use_slave = 1'b0;
  logic [31:0] slv_data = '0;
  logic [31:0] slv_rx = '0;
  logic [5:0]  slv_idx = '0;
  logic        slv_miso;
  int          rise_cnt = 0, fall_cnt = 0, mosi_viol = 0, runt_viol = 0, high_run = 0;
  logic        prev_mosi = 1'b0;

  always #5 sclk_i = ~sclk_i;

  spi_master #(
    .CLK_DIV(CLK_DIV), .CS_SETUP(CS_SETUP), .CS_HOLD(CS_HOLD), .CS_IDLE(CS_IDLE)
  ) dut (
    .sclk_i    (sclk_i),
    .rst_ni    (rst_ni),
    .start_i   (start_i),
    .tx_data_i (tx_data_i),
    .rx_data_o (rx_data_o),
    .busy_o    (busy_o),
    .done_o    (done_o),
    .spi_sclk_o(spi_sclk_o),
    .spi_ss_no (spi_ss_no),
    .spi_mosi_o(spi_mosi_o),
    .spi_miso_i(spi_miso_i)
`ifdef SPI_MASTER_IRQ_EN
    ,
    .irq_o     (irq_o),
    .irq_clr_i (irq_clr_i)
`endif
  );

  assign slv_miso   = slv_data[~slv_idx[4:0]];
  assign spi_miso_i = use_slave ? slv_miso : spi_mosi_o;

  always @(negedge spi_sclk_o or posedge spi_ss_no) begin
    if (spi_ss_no) slv_idx <= '0;
    else           slv_idx <= slv_idx + 6'd1;
  end

  always @(posedge spi_sclk_o) begin
    rise_cnt <= rise_cnt + 1;
    if (!spi_ss_no) slv_rx <= {slv_rx[30:0], spi_mosi_o};
  end

  always @(negedge spi_sclk_o) fall_cnt <= fall_cnt + 1;

  always @(negedge sclk_i) begin
    prev_mosi <= spi_mosi_o;
    if (spi_sclk_o && spi_mosi_o !== prev_mosi) mosi_viol <= mosi_viol + 1;
    if (!rst_ni) high_run <= 0;
    else if (spi_sclk_o) high_run <= high_run + 1;
    else begin
      if (high_run != 0 && high_run != CLK_DIV) runt_viol <= runt_viol + 1;
      high_run <= 0;
    end
  end

  task automatic do_frame(input logic [31:0] tx, input int pulse_bit, input int pulse_idx,
                          input bit clr_on_done, output logic [31:0] rx, output int busy_len,
                          output int ss_len, output int done_cnt, output int rises,
                          output int falls, output bit timeout);
    int r0, f0;
    bit pulsed;
    r0 = rise_cnt; f0 = fall_cnt; pulsed = 1'b0;
    busy_len = 0; ss_len = 0; done_cnt = 0; rx = 'x;
    @(negedge sclk_i); start_i = 1'b1; tx_data_i = tx;
    @(negedge sclk_i); start_i = 1'b0; tx_data_i = ~tx;
    for (int n = 0; n < 400; n++) begin
      if (!busy_o) break;
      busy_len++;
      if (!spi_ss_no) ss_len++;
      if (done_o) begin done_cnt++; rx = rx_data_o; end
      irq_clr_i = clr_on_done && done_o;
      start_i = 1'b0;
      if (pulse_bit >= 0 && !pulsed && rise_cnt - r0 == pulse_bit) begin
        start_i = 1'b1; tx_data_i = 32'hFFFF_FFFF; pulsed = 1'b1;
      end
      if (n == pulse_idx) start_i = 1'b1;
      @(negedge sclk_i);
    end
    timeout = busy_o;
    start_i = 1'b0; irq_clr_i = 1'b0;
    rises = rise_cnt - r0; falls = fall_cnt - f0;
  endtask

  task automatic test_reset();
    #12;
    checks++; if (rx_data_o !== 32'h0) begin errors++; $display("FAIL reset_rx got %h want 0", rx_data_o); end
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy_o); end
    checks++; if (done_o !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done_o); end
    checks++; if (spi_sclk_o !== 1'b0) begin errors++; $display("FAIL reset_sclk got %b want 0", spi_sclk_o); end
    checks++; if (spi_ss_no !== 1'b1) begin errors++; $display("FAIL reset_ss got %b want 1", spi_ss_no); end
    checks++; if (spi_mosi_o !== 1'b0) begin errors++; $display("FAIL reset_mosi got %b want 0", spi_mosi_o); end
    @(negedge sclk_i); rst_ni = 1'b1;
    repeat (2) @(negedge sclk_i);
  endtask

  task automatic test_loopback();
    logic [31:0] rx; int bl, sl, dc, ri, fa; bit to;
    use_slave = 1'b0;
    do_frame(32'hA5C3_0F81, -1, -1, 1'b0, rx, bl, sl, dc, ri, fa, to);
    checks++; if (to) begin errors++; $display("FAIL loop_timeout busy still high"); end
    checks++; if (rx !== 32'hA5C3_0F81) begin errors++; $display("FAIL loop_rx got %h want a5c30f81", rx); end
    checks++; if (slv_rx !== 32'hA5C3_0F81) begin errors++; $display("FAIL loop_mosi_order got %h want a5c30f81", slv_rx); end
    checks++; if (dc != 1) begin errors++; $display("FAIL loop_done_cycles got %0d want 1", dc); end
    checks++; if (ri != 32) begin errors++; $display("FAIL loop_rises got %0d want 32", ri); end
    checks++; if (fa != 32) begin errors++; $display("FAIL loop_falls got %0d want 32", fa); end
    checks++; if (bl != BUSY_LEN) begin errors++; $display("FAIL loop_busy_len got %0d want %0d", bl, BUSY_LEN); end
    checks++; if (sl != SS_LEN) begin errors++; $display("FAIL loop_ss_len got %0d want %0d", sl, SS_LEN); end
    repeat (5) @(negedge sclk_i);
    checks++; if (rx_data_o !== 32'hA5C3_0F81) begin errors++; $display("FAIL loop_rx_hold got %h want a5c30f81", rx_data_o); end
  endtask

  task automatic test_slave();
    logic [31:0] rx; int bl, sl, dc, ri, fa; bit to;
    use_slave = 1'b1; slv_data = 32'hDEAD_BEEF;
    do_frame(32'h1234_5678, -1, -1, 1'b0, rx, bl, sl, dc, ri, fa, to);
    checks++; if (to) begin errors++; $display("FAIL slave_timeout busy still high"); end
    checks++; if (rx !== 32'hDEAD_BEEF) begin errors++; $display("FAIL slave_rx got %h want deadbeef", rx); end
    checks++; if (slv_rx !== 32'h1234_5678) begin errors++; $display("FAIL slave_data_o got %h want 12345678", slv_rx); end
    checks++; if (dc != 1) begin errors++; $display("FAIL slave_done got %0d want 1", dc); end
    use_slave = 1'b0;
  endtask

  task automatic test_start_dropped();
    logic [31:0] rx; int bl, sl, dc, ri, fa, extra; bit to;
    do_frame(32'h3C96_5AA5, 10, -1, 1'b0, rx, bl, sl, dc, ri, fa, to);
    checks++; if (rx !== 32'h3C96_5AA5) begin errors++; $display("FAIL midstart_rx got %h want 3c965aa5", rx); end
    checks++; if (ri != 32) begin errors++; $display("FAIL midstart_rises got %0d want 32", ri); end
    checks++; if (bl != BUSY_LEN) begin errors++; $display("FAIL midstart_busy got %0d want %0d", bl, BUSY_LEN); end
    extra = 0;
    repeat (20) begin @(negedge sclk_i); if (busy_o || !spi_ss_no) extra++; end
    checks++; if (extra != 0) begin errors++; $display("FAIL midstart_second_frame got %0d busy cycles want 0", extra); end
    do_frame(32'h8000_0001, -1, BUSY_LEN - 1, 1'b0, rx, bl, sl, dc, ri, fa, to);
    checks++; if (rx !== 32'h8000_0001) begin errors++; $display("FAIL gapstart_rx got %h want 80000001", rx); end
    extra = 0;
    repeat (20) begin @(negedge sclk_i); if (busy_o || !spi_ss_no) extra++; end
    checks++; if (extra != 0) begin errors++; $display("FAIL gapstart_second_frame got %0d busy cycles want 0", extra); end
  endtask

  task automatic test_protocol();
    checks++; if (mosi_viol != 0) begin errors++; $display("FAIL mosi_while_sclk_high got %0d want 0", mosi_viol); end
    checks++; if (runt_viol != 0) begin errors++; $display("FAIL sclk_high_half got %0d runts want 0", runt_viol); end
  endtask

  task automatic test_abort();
    logic [31:0] rx; int bl, sl, dc, ri, fa, r0, seen_done; bit to;
    r0 = rise_cnt; seen_done = 0;
    @(negedge sclk_i); start_i = 1'b1; tx_data_i = 32'hF0F0_F0F0;
    @(negedge sclk_i); start_i = 1'b0;
    for (int n = 0; n < 300; n++) begin
      if (rise_cnt - r0 >= 17) break;
      if (done_o) seen_done++;
      @(negedge sclk_i);
    end
    checks++; if (rise_cnt - r0 != 17) begin errors++; $display("FAIL abort_reach_bit got %0d rises want 17", rise_cnt - r0); end
    rst_ni = 1'b0;
    #1;
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL abort_busy got %b want 0", busy_o); end
    checks++; if (spi_ss_no !== 1'b1) begin errors++; $display("FAIL abort_ss got %b want 1", spi_ss_no); end
    checks++; if (spi_sclk_o !== 1'b0) begin errors++; $display("FAIL abort_sclk got %b want 0", spi_sclk_o); end
    checks++; if (spi_mosi_o !== 1'b0) begin errors++; $display("FAIL abort_mosi got %b want 0", spi_mosi_o); end
    checks++; if (rx_data_o !== 32'h0) begin errors++; $display("FAIL abort_rx got %h want 0", rx_data_o); end
    checks++; if (done_o !== 1'b0 || seen_done != 0) begin errors++; $display("FAIL abort_done got %b/%0d want 0", done_o, seen_done); end
    repeat (2) @(negedge sclk_i);
    rst_ni = 1'b1;
    repeat (2) @(negedge sclk_i);
    do_frame(32'h0000_0001, -1, -1, 1'b0, rx, bl, sl, dc, ri, fa, to);
    checks++; if (rx !== 32'h0000_0001) begin errors++; $display("FAIL post_abort_rx got %h want 00000001", rx); end
    checks++; if (ri != 32 || fa != 32) begin errors++; $display("FAIL post_abort_edges got %0d/%0d want 32/32", ri, fa); end
    checks++; if (bl != BUSY_LEN) begin errors++; $display("FAIL post_abort_busy got %0d want %0d", bl, BUSY_LEN); end
  endtask

`ifdef SPI_MASTER_IRQ_EN
  task automatic test_irq();
    logic [31:0] rx; int bl, sl, dc, ri, fa; bit to;
    checks++; if (irq_o !== 1'b0) begin errors++; $display("FAIL irq_idle got %b want 0", irq_o); end
    do_frame(32'h0000_00FF, -1, -1, 1'b0, rx, bl, sl, dc, ri, fa, to);
    checks++; if (irq_o !== 1'b1) begin errors++; $display("FAIL irq_set got %b want 1", irq_o); end
    repeat (5) @(negedge sclk_i);
    checks++; if (irq_o !== 1'b1) begin errors++; $display("FAIL irq_sticky got %b want 1", irq_o); end
    irq_clr_i = 1'b1;
    @(negedge sclk_i); irq_clr_i = 1'b0;
    checks++; if (irq_o !== 1'b0) begin errors++; $display("FAIL irq_clear got %b want 0", irq_o); end
    do_frame(32'h0000_0F00, -1, -1, 1'b1, rx, bl, sl, dc, ri, fa, to);
    checks++; if (irq_o !== 1'b1) begin errors++; $display("FAIL irq_set_wins got %b want 1", irq_o); end
  endtask
`endif

  initial begin
    test_reset();
    test_loopback();
    test_slave();
    test_start_dropped();
    test_protocol();
    test_abort();
`ifdef SPI_MASTER_IRQ_EN
    test_irq();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
